// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS core: EX/MEM pipeline register, data-memory
// req/ack sequencing for lw/sw, branch/jump redirect and forwarding to WB.
module mem_stage #(
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [5:0]        ALUopE,
    input  logic [31:0]       ALUOut_in,
    input  logic [31:0]       WriteData_in,
    input  logic [31:0]       PCPlus4_in,
    input  logic [31:0]       PCBranch_in,
    input  logic [4:0]        wb_addr_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic              pc_src,
    output logic [31:0]       pc_target,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic [5:0]        ALUopM,
    output logic [31:0]       ALUOutM,
    output logic [31:0]       ReadDataM,
    output logic [31:0]       PCPlus4M,
    output logic [4:0]        wb_addrM,
    output logic              addr_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_p0;
    state_t      state_nxt;

    logic        reg_write_p0;
    logic        mem_to_reg_p0;
    logic        mem_write_p0;
    logic        branch_p0;
    logic        jump_p0;
    logic [5:0]  alu_op_p0;
    logic [31:0] alu_out_p0;
    logic [31:0] write_data_p0;
    logic [31:0] pc_plus4_p0;
    logic [31:0] pc_branch_p0;
    logic [4:0]  wb_addr_p0;
    logic        misalign_p0;
    logic [31:0] read_data_p0;
    logic        addr_err_p0;

    logic        capture;
    logic        mem_op_in;
    logic        misalign_in;

    function automatic logic is_misaligned(input logic mem_op, input logic [1:0] byte_off);
        return mem_op & (byte_off != 2'b00);
    endfunction

    assign mem_op_in   = MemtoRegE | MemWriteE;
    assign misalign_in = is_misaligned(mem_op_in, ALUOut_in[1:0]);

    // ---- FSM state register ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // A misaligned op never leaves IDLE, so it costs one cycle like an ALU op.
    always_comb begin
        state_nxt = state_p0;
        capture   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        stall_out = 1'b0;
        RegWriteM = 1'b0;
        case (state_p0)
            IDLE: begin
                capture   = 1'b1;
                RegWriteM = reg_write_p0 & ~misalign_p0;
                if (mem_op_in && !misalign_in) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_req   = 1'b1;
                mem_we    = mem_write_p0;
                stall_out = 1'b1;
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- EX/MEM pipeline register ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            reg_write_p0  <= 1'b0;
            mem_to_reg_p0 <= 1'b0;
            mem_write_p0  <= 1'b0;
            branch_p0     <= 1'b0;
            jump_p0       <= 1'b0;
            alu_op_p0     <= 6'd0;
            alu_out_p0    <= 32'd0;
            write_data_p0 <= 32'd0;
            pc_plus4_p0   <= 32'd0;
            pc_branch_p0  <= 32'd0;
            wb_addr_p0    <= 5'd0;
            misalign_p0   <= 1'b0;
        end else if (capture) begin
            reg_write_p0  <= RegWriteE;
            mem_to_reg_p0 <= MemtoRegE;
            mem_write_p0  <= MemWriteE;
            branch_p0     <= BranchE;
            jump_p0       <= JumpE;
            alu_op_p0     <= ALUopE;
            alu_out_p0    <= ALUOut_in;
            write_data_p0 <= WriteData_in;
            pc_plus4_p0   <= PCPlus4_in;
            pc_branch_p0  <= PCBranch_in;
            wb_addr_p0    <= wb_addr_in;
            misalign_p0   <= misalign_in;
        end
    end

    // ---- load data and sticky error flag ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            read_data_p0 <= 32'd0;
            addr_err_p0  <= 1'b0;
        end else begin
            if (state_p0 == BUSY && mem_ack && mem_to_reg_p0) begin
                read_data_p0 <= mem_rdata;
            end
            if (capture && misalign_in) begin
                addr_err_p0 <= 1'b1;
            end
        end
    end

    // Redirect is decoded only from latched values; jump wins over branch.
    always_comb begin
        pc_src    = 1'b0;
        pc_target = pc_branch_p0;
        if (jump_p0) begin
            pc_src    = 1'b1;
            pc_target = alu_out_p0;
        end else if (branch_p0 && alu_out_p0 == 32'd1) begin
            pc_src = 1'b1;
        end
    end

    assign mem_addr  = alu_out_p0[ADDR_W+1:2];
    assign mem_wdata = write_data_p0;
    assign MemtoRegM = mem_to_reg_p0;
    assign ALUopM    = alu_op_p0;
    assign ALUOutM   = alu_out_p0;
    assign ReadDataM = read_data_p0;
    assign PCPlus4M  = pc_plus4_p0;
    assign wb_addrM  = wb_addr_p0;
    assign addr_err  = addr_err_p0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instruction streams checked against a transaction-level model.
module tb_mem_stage;

    localparam int ADDR_W = 16;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
    logic [5:0]        ALUopE;
    logic [31:0]       ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in;
    logic [4:0]        wb_addr_in;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_ack;
    logic              stall_out, pc_src;
    logic [31:0]       pc_target;
    logic              RegWriteM, MemtoRegM;
    logic [5:0]        ALUopM;
    logic [31:0]       ALUOutM, ReadDataM, PCPlus4M;
    logic [4:0]        wb_addrM;
    logic              addr_err;

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUopE(ALUopE),
        .ALUOut_in(ALUOut_in), .WriteData_in(WriteData_in),
        .PCPlus4_in(PCPlus4_in), .PCBranch_in(PCBranch_in), .wb_addr_in(wb_addr_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
        .pc_src(pc_src), .pc_target(pc_target),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .ALUopM(ALUopM),
        .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .wb_addrM(wb_addrM), .addr_err(addr_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        br;
        logic        jp;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [31:0] pcb;
        logic [4:0]  wa;
    } instr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd_m;
    logic        addr_err_m;
    logic [31:0] dmem [logic [ADDR_W-1:0]];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input instr_t in);
        RegWriteE    = in.rw;
        MemtoRegE    = in.m2r;
        MemWriteE    = in.mw;
        BranchE      = in.br;
        JumpE        = in.jp;
        ALUopE       = in.op;
        ALUOut_in    = in.alu;
        WriteData_in = in.wd;
        PCPlus4_in   = in.pc4;
        PCBranch_in  = in.pcb;
        wb_addr_in   = in.wa;
    endtask

    function automatic instr_t blank();
        instr_t i;
        i     = '0;
        i.op  = 6'($urandom);
        i.wd  = $urandom;
        i.pc4 = $urandom;
        i.pcb = $urandom;
        i.wa  = 5'($urandom);
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i = blank();
        case ($urandom_range(0, 5))
            0: begin i.rw = 1'($urandom); i.alu = $urandom; end
            1: begin i.rw = 1'b1; i.m2r = 1'b1; i.alu = 32'($urandom_range(0, 63)) << 2; end
            2: begin i.mw = 1'b1; i.alu = 32'($urandom_range(0, 63)) << 2; end
            3: begin i.br = 1'b1; i.alu = 32'($urandom_range(0, 2)); end
            4: begin i.jp = 1'b1; i.rw = 1'($urandom); i.alu = $urandom; end
            default: begin
                i.m2r = 1'($urandom);
                i.mw  = ~i.m2r;
                i.rw  = i.m2r;
                i.alu = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            end
        endcase
        return i;
    endfunction

    // Called at a falling edge with the stage idle; returns at the falling
    // edge of the cycle in which the instruction's results are presented.
    task automatic issue(input instr_t in, input int n_wait, input logic spur_ack);
        logic        mem_op, mis, busy, exp_src;
        logic [31:0] exp_tgt, val;
        logic [ADDR_W-1:0] exp_addr;
        mem_op   = in.m2r | in.mw;
        mis      = mem_op && (in.alu[1:0] != 2'b00);
        busy     = mem_op && !mis;
        exp_addr = in.alu[ADDR_W+1:2];
        exp_src  = in.jp || (in.br && in.alu == 32'd1);
        exp_tgt  = in.jp ? in.alu : in.pcb;

        drive(in);
        mem_ack   = busy ? 1'b0 : spur_ack;
        mem_rdata = $urandom;
        @(posedge CLK);
        @(negedge CLK);
        mem_ack = 1'b0;
        if (mis) addr_err_m = 1'b1;

        if (busy) begin
            for (int k = 1; k <= n_wait; k++) begin
                check_val("busy_req", 32'(mem_req), 32'd1);
                check_val("busy_stall", 32'(stall_out), 32'd1);
                check_val("busy_we", 32'(mem_we), 32'(in.mw));
                check_val("busy_addr", 32'(mem_addr), 32'(exp_addr));
                if (in.mw) check_val("busy_wdata", mem_wdata, in.wd);
                check_val("busy_regwr", 32'(RegWriteM), 32'd0);
                check_val("busy_pcsrc", 32'(pc_src), 32'd0);
                check_val("busy_hold_alu", ALUOutM, in.alu);
                drive(blank() ^ instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom}));
                mem_rdata = $urandom;
                mem_ack   = 1'b0;
                if (k == n_wait) begin
                    mem_ack = 1'b1;
                    if (in.m2r) begin
                        if (dmem.exists(exp_addr)) val = dmem[exp_addr];
                        else begin
                            val = $urandom;
                            dmem[exp_addr] = val;
                        end
                        mem_rdata = val;
                        rd_m      = val;
                    end else begin
                        dmem[exp_addr] = in.wd;
                    end
                end
                @(posedge CLK);
                @(negedge CLK);
                mem_ack = 1'b0;
            end
        end

        check_val("res_stall", 32'(stall_out), 32'd0);
        check_val("res_req", 32'(mem_req), 32'd0);
        check_val("res_regwr", 32'(RegWriteM), 32'(in.rw && !mis));
        check_val("res_rdata", ReadDataM, rd_m);
        check_val("res_alu", ALUOutM, in.alu);
        check_val("res_wa", 32'(wb_addrM), 32'(in.wa));
        check_val("res_m2r", 32'(MemtoRegM), 32'(in.m2r));
        check_val("res_op", 32'(ALUopM), 32'(in.op));
        check_val("res_pc4", PCPlus4M, in.pc4);
        check_val("res_pcsrc", 32'(pc_src), 32'(exp_src));
        check_val("res_tgt", pc_target, exp_tgt);
        check_val("res_aerr", 32'(addr_err), 32'(addr_err_m));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"}, 32'(mem_req), 32'd0);
        check_val({tag, "_stall"}, 32'(stall_out), 32'd0);
        check_val({tag, "_we"}, 32'(mem_we), 32'd0);
        check_val({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_val({tag, "_regwr"}, 32'(RegWriteM), 32'd0);
        check_val({tag, "_alu"}, ALUOutM, 32'd0);
        check_val({tag, "_rdata"}, ReadDataM, 32'd0);
        check_val({tag, "_tgt"}, pc_target, 32'd0);
        check_val({tag, "_pcsrc"}, 32'(pc_src), 32'd0);
        check_val({tag, "_wa"}, 32'(wb_addrM), 32'd0);
        check_val({tag, "_aerr"}, 32'(addr_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        instr_t i;
        RESET      = 1'b1;
        drive('0);
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        rd_m       = 32'd0;
        addr_err_m = 1'b0;
        repeat (2) @(negedge CLK);
        check_all_zero("rst_init");
        RESET = 1'b0;

        // addu passthrough
        i = blank(); i.rw = 1'b1; i.alu = 32'h0000_0007; i.wa = 5'd8;
        issue(i, 1, 1'b0);
        // lw 0x10, ack in third busy cycle
        dmem[14'd4] = 32'hDEAD_BEEF;
        i = blank(); i.rw = 1'b1; i.m2r = 1'b1; i.alu = 32'h10;
        issue(i, 3, 1'b0);
        check_val("lw_data", ReadDataM, 32'hDEAD_BEEF);
        // sw 0x20 zero-wait
        i = blank(); i.mw = 1'b1; i.alu = 32'h20; i.wd = 32'h1234;
        issue(i, 1, 1'b0);
        // beq taken / not taken, jr
        i = blank(); i.br = 1'b1; i.alu = 32'd1; i.pcb = 32'h40;
        issue(i, 1, 1'b0);
        i = blank(); i.br = 1'b1; i.alu = 32'd0; i.pcb = 32'h40;
        issue(i, 1, 1'b0);
        i = blank(); i.jp = 1'b1; i.alu = 32'h100;
        issue(i, 1, 1'b0);
        // spurious ack while idle
        i = blank(); i.rw = 1'b1; i.alu = $urandom;
        issue(i, 1, 1'b1);
        // misaligned lw
        i = blank(); i.rw = 1'b1; i.m2r = 1'b1; i.alu = 32'h13;
        issue(i, 1, 1'b0);
        i = blank(); i.alu = $urandom;
        issue(i, 1, 1'b0);

        // reset in the middle of a busy load
        i = blank(); i.rw = 1'b1; i.m2r = 1'b1; i.alu = 32'h44;
        drive(i);
        @(posedge CLK);
        @(negedge CLK);
        check_val("pre_rst_req", 32'(mem_req), 32'd1);
        #2 RESET = 1'b1;
        #1 check_all_zero("rst_busy");
        @(negedge CLK);
        RESET      = 1'b0;
        rd_m       = 32'd0;
        addr_err_m = 1'b0;
        i = blank(); i.rw = 1'b1; i.alu = 32'h0000_0007; i.wa = 5'd8;
        issue(i, 1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            issue(rand_instr(), $urandom_range(1, 4), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage of the five-stage MIPS core: holds the EX/MEM pipeline register, performs `lw`/`sw` accesses to an external word-addressed data memory over a req/ack handshake, resolves branch and jump redirects, and forwards results to WB_stage. It stalls the upstream stages while a memory access is outstanding and sits between EX_stage (producer) and WB_stage (consumer).

## Interface
Parameters:
- ADDR_W, default 16: word-address width driven to data memory.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE  in  1 each  control from EX_stage.
- ALUopE  in  6  opcode of the EX instruction.
- ALUOut_in  in  32  ALU result: byte address, branch flag (1 = taken) or jump target.
- WriteData_in  in  32  `sw` store data.
- PCPlus4_in, PCBranch_in  in  32 each  PC+4 and branch target.
- wb_addr_in  in  5  destination register.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write (`sw`).
- mem_addr  out  ADDR_W  word address = ALUOutM[ADDR_W+1:2].
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid while mem_ack = 1.
- mem_ack  in  1  access complete.
- stall_out  out  1  1 = EX and earlier stages must hold.
- pc_src  out  1  1 = redirect fetch to pc_target.
- pc_target  out  32  redirect address.
- RegWriteM, MemtoRegM  out  1 each  control to WB.
- ALUopM  out  6  opcode to WB (`jal` detection).
- ALUOutM, ReadDataM, PCPlus4M  out  32 each  data to WB.
- wb_addrM  out  5  destination to WB.
- addr_err  out  1  sticky misaligned-access flag.

## Operation
- Pipeline register: on posedge CLK with stall_out = 0, capture all `*E`/`*_in` inputs; with stall_out = 1, hold all of them.
- Memory-op instruction: captured MemtoRegE = 1 or MemWriteE = 1.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY at the capturing edge when the incoming instruction is a memory op and ALUOut_in[1:0] = 00.
  - BUSY -> IDLE at the edge where mem_ack = 1 is sampled. On that edge, ReadDataM <= mem_rdata for a load.
  - BUSY never captures a new instruction.
- mem_req = (state == BUSY). mem_we = MemWrite latch & BUSY. mem_addr and mem_wdata come from the latched values and stay stable throughout BUSY.
- stall_out = (state == BUSY).
- Misaligned access (ALUOut_in[1:0] != 00 on a memory op):
  - The FSM stays IDLE and no request is issued.
  - addr_err is set and held until RESET.
  - RegWriteM is forced to 0 for that instruction.
- RegWriteM = latched RegWrite & (state == IDLE) & not misaligned. WB therefore never sees a load's write before its data arrives.
- Redirect, purely from latched values:
  - Jump latch = 1: pc_src = 1, pc_target = ALUOutM (covers `j`, `jal`, `jr`).
  - Else Branch latch = 1 and ALUOutM == 1: pc_src = 1, pc_target = PCBranch latch.
  - Otherwise pc_src = 0, pc_target = PCBranch latch.
- Branch/jump and memory ops are mutually exclusive, so pc_src is never asserted while BUSY.
- A mem_ack seen while IDLE is ignored.

## Timing
- Reset: every output and internal register is 0, state is IDLE, addr_err = 0. RESET asserted during BUSY aborts the access: mem_req drops immediately and no write-back occurs.
- Non-memory instruction: occupies the stage for 1 cycle; outputs are valid the cycle after capture.
- Memory op with the ack arriving in the Nth BUSY cycle (N >= 1): occupies N+1 cycles.
  - stall_out = 1 for exactly N cycles.
  - Load result is on ReadDataM, with RegWriteM = 1, in the cycle after the ack edge.
  - The next instruction is captured at the end of that cycle.
- Zero-wait memory (ack in the first BUSY cycle) gives 2 cycles per load or store.
- pc_src is a one-cycle pulse per branch or jump. Upstream flush is the fetch stage's responsibility.

## Test plan
- Reset: RESET = 1 mid-run with state BUSY -> mem_req = 0, stall_out = 0, all outputs 0 the same cycle; after release, the next ALU instruction proceeds normally.
- ALU passthrough: `addu` with ALUOut_in = 0x0000_0007, wb_addr_in = 8, RegWriteE = 1 -> next cycle ALUOutM = 7, wb_addrM = 8, RegWriteM = 1, stall_out = 0.
- Load with 3-cycle ack delay: ALUOut_in = 0x0000_0010, mem_ack in the 3rd BUSY cycle with mem_rdata = 0xDEAD_BEEF:
  - mem_addr = 4 and stall_out = 1 for 3 cycles.
  - Then ReadDataM = 0xDEAD_BEEF, RegWriteM = 1 for 1 cycle.
- Store zero-wait: `sw` at address 0x20 with data 0x1234 -> mem_we = 1, mem_addr = 8, mem_wdata = 0x1234 for 1 cycle; RegWriteM = 0 throughout.
- Branch/jump:
  - `beq` with ALUOutM = 1, PCBranch_in = 0x40 -> pc_src = 1, pc_target = 0x40.
  - Same with ALUOutM = 0 -> pc_src = 0.
  - `jr` with ALUOut_in = 0x100 -> pc_target = 0x100.
- Misaligned/spurious:
  - `lw` at address 0x13 -> no mem_req, addr_err = 1 (sticky), RegWriteM = 0.
  - mem_ack pulsed while IDLE -> no state change.
